intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 45 ++++
 rtl/intr_ctrl_edge_det.sv | 29 ++
 rtl/intr_ctrl.sv | 148 ++++++++++++++
 tb/tb_intr_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - core85 interrupt source codes, restart vectors and RIM/SIM bit positions
package intr_ctrl_pkg;

    typedef logic [2:0] src_t;

    localparam src_t SRC_NONE  = 3'd0;
    localparam src_t SRC_TRAP  = 3'd1;
    localparam src_t SRC_RST75 = 3'd2;
    localparam src_t SRC_RST65 = 3'd3;
    localparam src_t SRC_RST55 = 3'd4;
    localparam src_t SRC_INTR  = 3'd5;

    localparam logic [15:0] VEC_TRAP  = 16'h0024;
    localparam logic [15:0] VEC_RST75 = 16'h003C;
    localparam logic [15:0] VEC_RST65 = 16'h0034;
    localparam logic [15:0] VEC_RST55 = 16'h002C;
    localparam logic [15:0] VEC_NONE  = 16'h0000;

    // RIM image bit positions
    localparam int RIM_SID = 7;
    localparam int RIM_I75 = 6;
    localparam int RIM_I65 = 5;
    localparam int RIM_I55 = 4;
    localparam int RIM_IE  = 3;

    // SIM control bit positions; masks occupy [2:0] as {M7.5,M6.5,M5.5}
    localparam int SIM_SOD = 7;
    localparam int SIM_SDE = 6;
    localparam int SIM_R75 = 4;
    localparam int SIM_MSE = 3;
    localparam int MSK_75  = 2;
    localparam int MSK_65  = 1;
    localparam int MSK_55  = 0;

    function automatic logic [15:0] src_vec(input src_t src);
        case (src)
            SRC_TRAP:  src_vec = VEC_TRAP;
            SRC_RST75: src_vec = VEC_RST75;
            SRC_RST65: src_vec = VEC_RST65;
            SRC_RST55: src_vec = VEC_RST55;
            default:   src_vec = VEC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/intr_ctrl_edge_det.sv
// rtl/intr_ctrl_edge_det.sv - rising-edge detector on an s-stage level, blind to levels held through reset
module edge_det (
    input  logic clk_,
    input  logic rst_,
    input  logic lvl,
    output logic rise
);

    logic prev;
    logic vld;
    logic armed;

    // armed only once a genuine low sample is seen, so a pin high across reset release is not an edge
    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            prev  <= 1'b0;
            vld   <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= lvl;
            vld  <= 1'b1;
            if (vld && !lvl)
                armed <= 1'b1;
        end
    end

    assign rise = lvl & ~prev & armed;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - 8085-style interrupt controller; optional serial SID/SOD under INTR_SERIAL_EN
module intr_ctrl
    import intr_ctrl_pkg::*;
(
    input  logic        clk_,
    input  logic        rst_,
    input  logic        trap,
    input  logic        rst75,
    input  logic        rst65,
    input  logic        rst55,
    input  logic        intr,
    input  logic        ack,
    input  logic        ei,
    input  logic        di,
    input  logic        sim_wr,
    input  logic [7:0]  sim_dat,
`ifdef INTR_SERIAL_EN
    input  logic        sid,
`endif
    output logic [7:0]  rim_dat,
    output logic        int_req,
    output logic [2:0]  int_src,
    output logic [15:0] int_vec,
    output logic        inte
`ifdef INTR_SERIAL_EN
    ,
    output logic        sod
`endif
);

    logic       trap_s, r75_s, r65_s, r55_s, intr_s;
    logic       trap_rise, r75_rise;
    logic       trap_lat, r75_lat;
    logic [2:0] mask;
    logic       ack_fire, clr_trap, clr_r75, sim_r75_clr;
    logic       eff_trap, eff_r75, eff_ie;
    src_t       nxt_src;
    logic       sid_bit;

    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            trap_s <= 1'b0;
            r75_s  <= 1'b0;
            r65_s  <= 1'b0;
            r55_s  <= 1'b0;
            intr_s <= 1'b0;
        end else begin
            trap_s <= trap;
            r75_s  <= rst75;
            r65_s  <= rst65;
            r55_s  <= rst55;
            intr_s <= intr;
        end
    end

    edge_det u_trap_edge (.clk_(clk_), .rst_(rst_), .lvl(trap_s), .rise(trap_rise));
    edge_det u_r75_edge  (.clk_(clk_), .rst_(rst_), .lvl(r75_s),  .rise(r75_rise));

    assign ack_fire    = ack & int_req;
    assign clr_trap    = ack_fire && (int_src == SRC_TRAP);
    assign clr_r75     = ack_fire && (int_src == SRC_RST75);
    assign sim_r75_clr = sim_wr & sim_dat[SIM_R75];

    // a fresh rising edge outranks any clear landing in the same cycle
    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            trap_lat <= 1'b0;
            r75_lat  <= 1'b0;
            inte     <= 1'b0;
            mask     <= 3'b111;
        end else begin
            trap_lat <= trap_rise | (trap_lat & ~clr_trap);
            r75_lat  <= r75_rise | (r75_lat & ~clr_r75 & ~sim_r75_clr);
            if (di || ack_fire)
                inte <= 1'b0;
            else if (ei)
                inte <= 1'b1;
            if (sim_wr && sim_dat[SIM_MSE])
                mask <= sim_dat[2:0];
        end
    end

    // the served source and inte are withdrawn before re-arbitration so an ack drops int_req at once
    assign eff_trap = trap_lat & ~clr_trap;
    assign eff_r75  = r75_lat & ~clr_r75;
    assign eff_ie   = inte & ~ack_fire;

    always_comb begin
        nxt_src = SRC_NONE;
        if (eff_trap && trap_s)
            nxt_src = SRC_TRAP;
        else if (eff_ie && !mask[MSK_75] && eff_r75)
            nxt_src = SRC_RST75;
        else if (eff_ie && !mask[MSK_65] && r65_s)
            nxt_src = SRC_RST65;
        else if (eff_ie && !mask[MSK_55] && r55_s)
            nxt_src = SRC_RST55;
        else if (eff_ie && intr_s)
            nxt_src = SRC_INTR;
    end

    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            int_req <= 1'b0;
            int_src <= SRC_NONE;
            int_vec <= VEC_NONE;
        end else begin
            int_req <= (nxt_src != SRC_NONE);
            int_src <= nxt_src;
            int_vec <= src_vec(nxt_src);
        end
    end

`ifdef INTR_SERIAL_EN
    logic sid_s;
    logic unused_sim;

    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            sid_s <= 1'b0;
            sod   <= 1'b0;
        end else begin
            sid_s <= sid;
            if (sim_wr && sim_dat[SIM_SDE])
                sod <= sim_dat[SIM_SOD];
        end
    end

    assign sid_bit    = sid_s;
    assign unused_sim = sim_dat[5];
`else
    logic unused_sim;

    assign sid_bit    = 1'b0;
    assign unused_sim = ^sim_dat[7:5];
`endif

    always_comb begin
        rim_dat          = 8'h00;
        rim_dat[RIM_SID] = sid_bit;
        rim_dat[RIM_I75] = r75_lat;
        rim_dat[RIM_I65] = r65_s;
        rim_dat[RIM_I55] = r55_s;
        rim_dat[RIM_IE]  = inte;
        rim_dat[2:0]     = mask;
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed bench for intr_ctrl with a source-table reference model
module tb_intr_ctrl;

    logic        clk_ = 1'b0;
    logic        rst_ = 1'b0;
    logic        trap = 0, rst75 = 0, rst65 = 0, rst55 = 0, intr = 0;
    logic        ack = 0, ei = 0, di = 0, sim_wr = 0;
    logic [7:0]  sim_dat = 8'h00;
    logic [7:0]  rim_dat;
    logic        int_req;
    logic [2:0]  int_src;
    logic [15:0] int_vec;
    logic        inte;
`ifdef INTR_SERIAL_EN
    logic        sid = 1'b0;
    logic        sod;
`endif

    intr_ctrl dut (
        .clk_(clk_), .rst_(rst_),
        .trap(trap), .rst75(rst75), .rst65(rst65), .rst55(rst55), .intr(intr),
        .ack(ack), .ei(ei), .di(di), .sim_wr(sim_wr), .sim_dat(sim_dat),
`ifdef INTR_SERIAL_EN
        .sid(sid),
`endif
        .rim_dat(rim_dat), .int_req(int_req), .int_src(int_src), .int_vec(int_vec),
        .inte(inte)
`ifdef INTR_SERIAL_EN
        , .sod(sod)
`endif
    );

    always #5 clk_ = ~clk_;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sources indexed 1..5 in priority order (1 = TRAP ... 5 = INTR)
    logic [15:0] vec_tab [0:5] = '{16'h0000, 16'h0024, 16'h003C, 16'h0034, 16'h002C, 16'h0000};
    bit          m_s     [1:5];
    bit          m_prev  [1:2];
    bit          m_armed [1:2];
    bit          m_lat   [1:2];
    bit          m_edge  [1:2];
    bit          m_pend  [1:5];
    bit          m_valid, m_ie, m_req, m_sid, m_sod, m_fire;
    bit [2:0]    m_mask;
    int          m_src, m_served, m_new;

    always @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            for (int k = 1; k <= 5; k++) m_s[k] = 0;
            for (int k = 1; k <= 2; k++) begin
                m_prev[k] = 0; m_armed[k] = 0; m_lat[k] = 0;
            end
            m_valid = 0; m_ie = 0; m_req = 0; m_src = 0; m_mask = 3'b111;
            m_sid = 0; m_sod = 0;
        end else begin
            m_fire   = ack && m_req;
            m_served = m_fire ? m_src : 0;
            for (int k = 1; k <= 2; k++) m_edge[k] = m_s[k] && !m_prev[k] && m_armed[k];
            m_pend[1] = m_lat[1] && m_served != 1 && m_s[1];
            m_pend[2] = m_lat[2] && m_served != 2 && m_ie && !m_fire && !m_mask[2];
            for (int k = 3; k <= 4; k++) m_pend[k] = m_s[k] && m_ie && !m_fire && !m_mask[4-k];
            m_pend[5] = m_s[5] && m_ie && !m_fire;
            m_new = 0;
            for (int k = 5; k >= 1; k--) if (m_pend[k]) m_new = k;
            m_lat[1] = m_edge[1] || (m_lat[1] && m_served != 1);
            m_lat[2] = m_edge[2] || (m_lat[2] && m_served != 2 && !(sim_wr && sim_dat[4]));
            if (di || m_fire) m_ie = 0;
            else if (ei) m_ie = 1;
            if (sim_wr && sim_dat[3]) m_mask = sim_dat[2:0];
`ifdef INTR_SERIAL_EN
            if (sim_wr && sim_dat[6]) m_sod = sim_dat[7];
            m_sid = sid;
`endif
            for (int k = 1; k <= 2; k++) begin
                m_armed[k] = m_armed[k] || (m_valid && !m_s[k]);
                m_prev[k]  = m_s[k];
            end
            m_valid = 1;
            m_s[1] = trap; m_s[2] = rst75; m_s[3] = rst65; m_s[4] = rst55; m_s[5] = intr;
            m_req = (m_new != 0);
            m_src = m_new;
        end
    end

    always @(negedge clk_) begin
        if (!rst_) begin
            chk("model_req", int_req, m_req);
            chk("model_src", int_src, m_src);
            chk("model_vec", int_vec, vec_tab[m_src]);
            chk("model_inte", inte, m_ie);
            chk("model_rim", rim_dat, {m_sid, m_lat[2], m_s[3], m_s[4], m_ie, m_mask});
`ifdef INTR_SERIAL_EN
            chk("model_sod", sod, m_sod);
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_);
        #2;
    endtask

    task automatic sim(input logic [7:0] d);
        sim_wr = 1; sim_dat = d;
        tick();
        sim_wr = 0; sim_dat = 8'h00;
    endtask

    task automatic pulse_ei();
        ei = 1; tick(); ei = 0;
    endtask

    task automatic pulse_ack();
        ack = 1; tick(); ack = 0;
    endtask

    initial begin
        #1 rst_ = 1;
        tick(2);
        rst_ = 0;
        tick();
        chk("rst_req", int_req, 0);
        chk("rst_src", int_src, 0);
        chk("rst_vec", int_vec, 16'h0000);
        chk("rst_inte", inte, 0);
        chk("rst_rim", rim_dat, 8'h07);

        // masked and disabled: rst55 must not request
        rst55 = 1; tick(3);
        chk("r55_masked_req", int_req, 0);
        chk("r55_rim", rim_dat, 8'h17);
        rst55 = 0; tick();

        pulse_ei();
        sim(8'h08);
        chk("ei_unmask_rim", rim_dat, 8'h08);

        // rst75 pulse: request two edges after the sampling edge
        rst75 = 1; tick(); rst75 = 0;
        tick();
        chk("r75_n1_req", int_req, 0);
        tick();
        chk("r75_n2_req", int_req, 1);
        chk("r75_src", int_src, 2);
        chk("r75_vec", int_vec, 16'h003C);
        pulse_ack();
        chk("r75_ack_i75", rim_dat[6], 0);
        chk("r75_ack_inte", inte, 0);
        chk("r75_ack_req", int_req, 0);

        // trap with inte=0, then withdrawn before ack
        trap = 1; tick(3);
        chk("trap_req", int_req, 1);
        chk("trap_src", int_src, 1);
        chk("trap_vec", int_vec, 16'h0024);
        trap = 0; tick(2);
        chk("trap_drop_req", int_req, 0);
        pulse_ack();
        chk("ack_idle_req", int_req, 0);

        // rst65 beats intr; after service, intr alone
        pulse_ei();
        rst65 = 1; intr = 1; tick(2);
        chk("r65_src", int_src, 3);
        chk("r65_vec", int_vec, 16'h0034);
        pulse_ack();
        pulse_ei();
        rst65 = 0; tick(2);
        chk("intr_src", int_src, 5);
        chk("intr_vec", int_vec, 16'h0000);
        chk("intr_req", int_req, 1);
        intr = 0; di = 1; tick(); di = 0; tick();

        // rst75 edge coincident with SIM R7.5 clear: latch survives
        rst75 = 1; tick();
        sim(8'h10);
        chk("r75_vs_sim_rim", rim_dat, 8'h40);
        rst75 = 0;
        sim(8'h10);
        chk("sim_clr_rim", rim_dat, 8'h00);

        ei = 1; di = 1; tick(); ei = 0; di = 0;
        chk("di_beats_ei", inte, 0);

        // reset mid-request with rst75 held high across release
        pulse_ei();
        rst75 = 1; tick(3);
        chk("pre_rst_src", int_src, 2);
        rst_ = 1; #1;
        chk("async_rst_req", int_req, 0);
        tick(2);
        rst_ = 0;
        tick(4);
        chk("held_pin_req", int_req, 0);
        chk("held_pin_rim", rim_dat, 8'h07);
        rst75 = 0; tick(2);
        rst75 = 1; tick(2);
        chk("rearm_rim", rim_dat, 8'h47);
        rst75 = 0; tick(2);

`ifdef INTR_SERIAL_EN
        sim(8'hC0);
        chk("sod_set", sod, 1);
        sid = 1; tick();
        chk("sid_rim", rim_dat[7], 1);
        sim(8'h80);
        chk("sod_hold", sod, 1);
        sid = 0; tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
